// File: rtl/adder_ctrl_pkg.sv
// Shared types and constants for the byte-serial wide adder sequencer.
package adder_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } ctrl_state_t;

    localparam int BYTE_BITS = 8;
endpackage

// File: rtl/adder_8bit.sv
// Existing 8-bit datapath adder: unsigned sum with carry-in, overflow is the carry out.
module adder_8bit
    import adder_ctrl_pkg::*;
(
    input  logic [BYTE_BITS-1:0] a,
    input  logic [BYTE_BITS-1:0] b,
    input  logic                 carry_in,
    output logic [BYTE_BITS-1:0] sum,
    output logic                 overflow
);
    assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BYTE_BITS{1'b0}}, carry_in};
endmodule

// File: rtl/wide_adder_ctrl.sv
// Sequences one shared adder_8bit over NUM_BYTES cycles, LSB byte first, chaining carry,
// to add two NUM_BYTES*8-bit operands.
module wide_adder_ctrl
    import adder_ctrl_pkg::*;
#(
    parameter  int NUM_BYTES = 4,
    localparam int W         = NUM_BYTES * BYTE_BITS
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         overflow,
    output ctrl_state_t  dbg_state
);
    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef logic [NUM_BYTES-1:0][BYTE_BITS-1:0] bytes_t;

    ctrl_state_t          state;
    bytes_t               a_lat;
    bytes_t               b_lat;
    bytes_t               partial;
    bytes_t               partial_next;
    logic [IDX_W-1:0]     idx;
    logic                 carry_reg;
    logic [BYTE_BITS-1:0] byte_a;
    logic [BYTE_BITS-1:0] byte_b;
    logic [BYTE_BITS-1:0] byte_sum;
    logic                 byte_ovf;

    // Handshake: start is taken on any rising edge where the FSM is IDLE or DONE;
    // done pulses for one cycle with sum/overflow valid, and start while busy is dropped.

    always_comb begin
        byte_a       = '0;
        byte_b       = '0;
        partial_next = partial;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (idx == IDX_W'(i)) begin
                byte_a          = a_lat[i];
                byte_b          = b_lat[i];
                partial_next[i] = byte_sum;
            end
        end
    end

    adder_8bit u_adder (
        .a        (byte_a),
        .b        (byte_b),
        .carry_in (carry_reg),
        .sum      (byte_sum),
        .overflow (byte_ovf)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            a_lat     <= '0;
            b_lat     <= '0;
            partial   <= '0;
            idx       <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_lat     <= a;
                        b_lat     <= b;
                        carry_reg <= carry_in;
                        idx       <= '0;
                        partial   <= '0;
                        busy      <= 1'b1;
                        state     <= ADD;
                    end else begin
                        state <= IDLE;
                    end
                end
                ADD: begin
                    partial   <= partial_next;
                    carry_reg <= byte_ovf;
                    if (idx == LAST_IDX) begin
                        // Result becomes visible only as a whole, on the final byte.
                        sum      <= partial_next;
                        overflow <= byte_ovf;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;
endmodule

// File: tb/tb_wide_adder_ctrl.sv
// Self-checking bench for wide_adder_ctrl: directed scenarios plus randomized traffic,
// with a 4-byte and a 1-byte build checked against an arithmetic reference model.
module tb_wide_adder_ctrl;
    import adder_ctrl_pkg::*;

    localparam int NB = 4;
    localparam int W  = NB * 8;

    // clock / reset / stimulus signals
    logic         clk = 1'b0;
    logic         n_rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;

    logic         busy, done, overflow;
    logic [W-1:0] sum;
    ctrl_state_t  dbg_state;

    logic         busy1, done1, overflow1;
    logic [7:0]   sum1;
    ctrl_state_t  dbg_state1;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    wide_adder_ctrl #(.NUM_BYTES(NB)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .overflow  (overflow),
        .dbg_state (dbg_state)
    );

    wide_adder_ctrl #(.NUM_BYTES(1)) dut1 (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .a         (a[7:0]),
        .b         (b[7:0]),
        .carry_in  (carry_in),
        .busy      (busy1),
        .done      (done1),
        .sum       (sum1),
        .overflow  (overflow1),
        .dbg_state (dbg_state1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 20)
                $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an accepted op yields a+b+cin after a fixed number of ADD cycles.
    // Index 0 models the 4-byte build, index 1 the 1-byte build.
    int           m_rem  [2];
    logic [W:0]   m_pend [2];
    logic [W-1:0] m_sum  [2];
    logic         m_ovf  [2];
    logic         m_done [2];

    always @(posedge clk or negedge n_rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!n_rst) begin
                m_rem[k]  = 0;
                m_pend[k] = '0;
                m_sum[k]  = '0;
                m_ovf[k]  = 1'b0;
                m_done[k] = 1'b0;
            end else begin
                m_done[k] = 1'b0;
                if (m_rem[k] > 0) begin
                    m_rem[k]--;
                    if (m_rem[k] == 0) begin
                        m_done[k] = 1'b1;
                        if (k == 0) begin
                            {m_ovf[k], m_sum[k]} = m_pend[k];
                        end else begin
                            m_ovf[k] = m_pend[k][8];
                            m_sum[k] = {24'd0, m_pend[k][7:0]};
                        end
                    end
                end else if (start) begin
                    if (k == 0) begin
                        m_pend[k] = {1'b0, a} + {1'b0, b} + (W+1)'(carry_in);
                        m_rem[k]  = NB;
                    end else begin
                        m_pend[k] = (W+1)'({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(carry_in));
                        m_rem[k]  = 1;
                    end
                end
            end
        end
    end

    function automatic ctrl_state_t exp_state(input int k);
        if (m_rem[k] > 0) return ADD;
        if (m_done[k])    return DONE;
        return IDLE;
    endfunction

    // scoreboard compare, every cycle on the falling edge
    always @(negedge clk) begin
        check("busy",      busy,      m_rem[0] > 0);
        check("done",      done,      m_done[0]);
        check("sum",       sum,       m_sum[0]);
        check("overflow",  overflow,  m_ovf[0]);
        check("state",     dbg_state, exp_state(0));
        check("busy1",     busy1,     m_rem[1] > 0);
        check("done1",     done1,     m_done[1]);
        check("sum1",      sum1,      m_sum[1][7:0]);
        check("overflow1", overflow1, m_ovf[1]);
        check("state1",    dbg_state1, exp_state(1));
        if (m_done[0]) done_cnt++;
    end

    // driver tasks
    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
        start    = 1'b1;
        a        = ta;
        b        = tb_v;
        carry_in = tc;
    endtask

    task automatic wait_done(input int inject, input logic hold_en, input logic [W-1:0] hold_val,
                             output int cyc, output int busy_cnt);
        cyc      = 0;
        busy_cnt = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (inject != 0 && cyc == inject) begin
                start = 1'b1;
                a     = '1;
            end
            if (inject != 0 && cyc == inject + 1) start = 1'b0;
            if (busy) busy_cnt++;
            if (hold_en && !done) check("hold_sum", sum, hold_val);
        end while (!done && cyc < 20);
        check("done_seen", done, 1'b1);
    endtask

    int cyc, bcnt, extra, base, target;

    initial begin
        n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_ovf",  overflow, 0);
        #2 n_rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_sum",  sum,  0);

        // carry from byte 0 into byte 1
        @(negedge clk);
        drive(32'h0000_00FF, 32'h0000_0001, 1'b0);
        wait_done(0, 1'b0, '0, cyc, bcnt);
        check("t2_latency", cyc, 5);
        check("t2_busy_cycles", bcnt, 4);
        check("t2_busy_at_done", busy, 0);
        check("t2_sum", sum, 32'h0000_0100);
        check("t2_ovf", overflow, 0);
        @(negedge clk);
        check("t2_done_pulse", done, 0);

        // carry ripples through all bytes
        drive(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_done(0, 1'b0, '0, cyc, bcnt);
        check("t3_latency", cyc, 5);
        check("t3_sum", sum, 32'h0000_0000);
        check("t3_ovf", overflow, 1);

        // start during ADD is ignored
        @(negedge clk);
        drive(32'h1234_5678, 32'h1111_1111, 1'b0);
        wait_done(2, 1'b0, '0, cyc, bcnt);
        check("t4_latency", cyc, 5);
        check("t4_sum", sum, 32'h2345_6789);
        check("t4_ovf", overflow, 0);
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("t4_no_second_done", extra, 0);

        // back-to-back: new op accepted in the DONE cycle
        drive(32'h0000_0001, 32'h0000_0002, 1'b0);
        wait_done(0, 1'b0, '0, cyc, bcnt);
        check("t5_first_sum", sum, 32'h0000_0003);
        drive(32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done(0, 1'b1, 32'h0000_0003, cyc, bcnt);
        check("t5_latency", cyc, 5);
        check("t5_sum", sum, 32'h0000_0000);
        check("t5_ovf", overflow, 1);

        // reset mid-operation aborts it
        @(negedge clk);
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_sum",  sum,  0);
        check("t6_ovf",  overflow, 0);
        @(negedge clk);
        #2 n_rst = 1'b1;
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("t6_no_done", extra, 0);
        drive(32'h0001_0000, 32'h0000_FFFF, 1'b1);
        wait_done(0, 1'b0, '0, cyc, bcnt);
        check("t6_sum_after", sum, 32'h0002_0000);
        check("t6_ovf_after", overflow, 0);

        // randomized traffic with occasional reset pulses
        base   = done_cnt;
        target = base + 10000;
        for (int c = 0; c < 80000 && done_cnt < target; c++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) != 0);
            a        = $urandom;
            b        = $urandom;
            carry_in = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0: a = '1;
                1: b = ~a;
                2: b = '0;
                default: ;
            endcase
            if ($urandom_range(0, 1999) == 0) begin
                #2 n_rst = 1'b0;
                @(negedge clk);
                #2 n_rst = 1'b1;
            end
        end
        start = 1'b0;
        check("random_ops_completed", done_cnt >= target, 1);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
